// File: rtl/uart_pkg.sv
// Shared UART receive definitions: frame geometry, line levels, FSM states, parity helper.
package uart_pkg;

  localparam int DATA_W  = 8;
  localparam int FRAME_W = 11;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  function automatic logic parity_calc(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high async line; 2 clk latency, presets to 1 on reset.
// No flow control: a plain level path.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8 data + parity + stop; strobe ~10.5 bit times + 2 clk after start edge.
// No backpressure: each byte is presented for one cycle and held until the next frame.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic [DATA_W-1:0]  data_out,
  output logic [FRAME_W-1:0] frame_out,
  output logic               data_valid,
  output logic               parity_err,
  output logic               frame_err,
  output logic               busy
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              busy_d;
  logic              load;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    busy_d    = busy;
    load      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_s == START_BIT) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Half a bit in: confirm the start bit is still low, else treat as a glitch.
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (rx_s == START_BIT) begin
            state_d   = DATA;
            busy_d    = 1'b1;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[DATA_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          load  = 1'b1;
          if (rx_s == STOP_BIT) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = BREAK_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK_WAIT: begin
        if (rx_s == STOP_BIT) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      frame_out  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      busy       <= busy_d;
      data_valid <= load;
      // Byte is delivered even on errors; the flags let the consumer decide.
      if (load) begin
        data_out   <= shift_q;
        frame_out  <= {rx_s, par_q, shift_q, START_BIT};
        parity_err <= (par_q != parity_calc(shift_q, PARITY_ODD));
        frame_err  <= (rx_s != STOP_BIT);
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of frames plus hand-written break, glitch and reset sequences.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [7:0]  data_out;
  logic [10:0] frame_out;
  logic        data_valid, parity_err, frame_err, busy;

  uart_receiver #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .frame_out  (frame_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  d;
    logic [10:0] f;
    logic        pe;
    logic        fe;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       p;
    int         gap;
    logic       exp_pe;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   strobes = 0;
  int   exp_strobes = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic p, input logic s,
                          input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.f  = {s, p, d, 1'b0};
    e.pe = pe;
    e.fe = fe;
    exp_q.push_back(e);
    exp_strobes++;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rx = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  // Scoreboard: every strobe pops one expected frame.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) begin
        exp_t e;
        strobes++;
        check("valid_gap", {31'd0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got data_out %0h, expected no strobe", data_out);
        end else begin
          e = exp_q.pop_front();
          check("data_out",   {24'd0, data_out},   {24'd0, e.d});
          check("frame_out",  {21'd0, frame_out},  {21'd0, e.f});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
          check("frame_err",  {31'd0, frame_err},  {31'd0, e.fe});
        end
      end
      prev_valid = data_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    vec_t vecs[8];
    int   base;
    logic busy_seen;
    logic [10:0] f81;

    vecs[0] = '{d: 8'hA5, p: 1'b0, gap: 30, exp_pe: 1'b0};
    vecs[1] = '{d: 8'h07, p: 1'b0, gap: 30, exp_pe: 1'b1};
    vecs[2] = '{d: 8'h07, p: 1'b1, gap: 30, exp_pe: 1'b0};
    vecs[3] = '{d: 8'h55, p: 1'b0, gap: 0,  exp_pe: 1'b0};
    vecs[4] = '{d: 8'hFF, p: 1'b0, gap: 30, exp_pe: 1'b0};
    vecs[5] = '{d: 8'h00, p: 1'b1, gap: 30, exp_pe: 1'b1};
    vecs[6] = '{d: 8'h80, p: 1'b1, gap: 30, exp_pe: 1'b0};
    vecs[7] = '{d: 8'hE3, p: 1'b1, gap: 30, exp_pe: 1'b0};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out",   {24'd0, data_out},   32'd0);
    check("rst_frame_out",  {21'd0, frame_out},  32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_frame_err",  {31'd0, frame_err},  32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i].d, vecs[i].p, 1'b1, vecs[i].exp_pe, 1'b0);
      send_frame(vecs[i].d, vecs[i].p, 1'b1);
      repeat (vecs[i].gap) @(negedge clk);
    end

    // Framing error followed by a held break.
    base = strobes;
    push_exp(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("break_busy_held", {31'd0, busy}, 32'd1);
    check("break_one_strobe", strobes - base, 32'd1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("break_busy_clear", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);

    // Short glitch on an idle line.
    base = strobes;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("glitch_busy", {31'd0, busy_seen}, 32'd0);
    check("glitch_no_strobe", strobes - base, 32'd0);
    push_exp(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (30) @(negedge clk);

    // Reset in the middle of data bit 4 of 0x81.
    base = strobes;
    f81 = {1'b1, 1'b0, 8'h81, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx = f81[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = f81[5];
    repeat (7) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_busy",     {31'd0, busy},      32'd0);
    check("mid_rst_data_out", {24'd0, data_out},  32'd0);
    check("mid_rst_frame",    {21'd0, frame_out}, 32'd0);
    rx    = 1'b1;
    reset = 1'b0;
    repeat (CPB * 8) @(negedge clk);
    check("rst_no_strobe", strobes - base, 32'd0);
    push_exp(8'h42, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h42, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_strobe: got no strobe, expected data_out %0h", e.d);
    end
    repeat (20) @(negedge clk);
    check("strobe_total", strobes, exp_strobes);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
